// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates icache and dcache word requests onto one single-ported RAM.
// A granted master may complete up to BURST_MAX accesses before the other side gets a turn.
module mem_arbiter_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 2
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    input  logic              iREN_i,
    input  logic [ADDR_W-1:0] iaddr_i,
    output logic              iwait_o,
    output logic [DATA_W-1:0] iload_o,
    input  logic              dREN_i,
    input  logic              dWEN_i,
    input  logic [ADDR_W-1:0] daddr_i,
    input  logic [DATA_W-1:0] dstore_i,
    output logic              dwait_o,
    output logic [DATA_W-1:0] dload_o,
    output logic              ram_ren_o,
    output logic              ram_wen_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_store_o,
    input  logic [DATA_W-1:0] ram_load_i,
    input  logic              ram_ready_i,
    output logic              gnt_d_o
);

    localparam int CNT_W = $clog2(BURST_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             last_d_q, last_d_d;
    logic             gnt_d_q;

    logic             dReq, iReq;
    logic             dOwn, iOwn;
    logic             dDone, iDone;
    logic [CNT_W-1:0] cntInc;
    logic             unusedAddrBits;

    assign dReq   = dREN_i | dWEN_i;
    assign iReq   = iREN_i;
    assign dOwn   = (state_q == D_ACC);
    assign iOwn   = (state_q == I_ACC);
    assign cntInc = burst_cnt_q + CNT_ONE;

    // A completion needs the owner still requesting; a ready pulse arriving during reset is dropped.
    assign dDone = dOwn & dReq & ram_ready_i & ~RST_i;
    assign iDone = iOwn & iReq & ram_ready_i & ~RST_i;

    assign iwait_o = iReq & ~iDone;
    assign dwait_o = dReq & ~dDone;
    assign iload_o = iDone ? ram_load_i : '0;
    assign dload_o = dDone ? ram_load_i : '0;
    assign gnt_d_o = gnt_d_q;

    assign unusedAddrBits = ^{iaddr_i[1:0], daddr_i[1:0]};

    always_comb begin
        ram_ren_o   = 1'b0;
        ram_wen_o   = 1'b0;
        ram_addr_o  = '0;
        ram_store_o = '0;
        if (dOwn) begin
            ram_ren_o   = dREN_i & ~dWEN_i;
            ram_wen_o   = dWEN_i;
            ram_addr_o  = {daddr_i[ADDR_W-1:2], 2'b00};
            ram_store_o = dstore_i;
        end else if (iOwn) begin
            ram_ren_o  = iREN_i;
            ram_addr_o = {iaddr_i[ADDR_W-1:2], 2'b00};
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        last_d_d    = last_d_q;
        case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                // Under contention the side that was not served last gets the grant.
                if (dReq && (!iReq || !last_d_q)) begin
                    state_d = D_ACC;
                end else if (iReq) begin
                    state_d = I_ACC;
                end
            end
            D_ACC: begin
                if (!dReq) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end else if (dDone) begin
                    last_d_d = 1'b1;
                    if (cntInc == CNT_MAX) begin
                        state_d     = IDLE;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = cntInc;
                    end
                end
            end
            I_ACC: begin
                if (!iReq) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end else if (iDone) begin
                    last_d_d = 1'b0;
                    if (cntInc == CNT_MAX) begin
                        state_d     = IDLE;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = cntInc;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            last_d_q    <= 1'b0;
            gnt_d_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            last_d_q    <= last_d_d;
            gnt_d_q     <= (state_d == D_ACC);
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl: expected RAM transactions are queued when a cache
// request is driven and checked against the RAM port and load/wait lines at each ready pulse.
module tb_mem_arbiter_ctrl;

    logic        clock;
    logic        reset;
    logic        iRen;
    logic [31:0] iAddr;
    logic        iWait;
    logic [31:0] iLoad;
    logic        dRen;
    logic        dWen;
    logic [31:0] dAddr;
    logic [31:0] dStore;
    logic        dWait;
    logic [31:0] dLoad;
    logic        ramRen;
    logic        ramWen;
    logic [31:0] ramAddr;
    logic [31:0] ramStore;
    logic [31:0] ramLoad;
    logic        ramReady;
    logic        gntD;

    typedef struct {
        logic        isD;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t sb[$];
    int   nVectors;
    int   nMiscompares;

    mem_arbiter_ctrl #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(2)) dut (
        .CLK_i      (clock),
        .RST_i      (reset),
        .iREN_i     (iRen),
        .iaddr_i    (iAddr),
        .iwait_o    (iWait),
        .iload_o    (iLoad),
        .dREN_i     (dRen),
        .dWEN_i     (dWen),
        .daddr_i    (dAddr),
        .dstore_i   (dStore),
        .dwait_o    (dWait),
        .dload_o    (dLoad),
        .ram_ren_o  (ramRen),
        .ram_wen_o  (ramWen),
        .ram_addr_o (ramAddr),
        .ram_store_o(ramStore),
        .ram_load_i (ramLoad),
        .ram_ready_i(ramReady),
        .gnt_d_o    (gntD)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nVectors++;
        assert (observed === expected) else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; the RAM ready pulse only ever lasts one cycle.
    task automatic nextCycle();
        @(posedge clock);
        #1;
        ramReady = 1'b0;
        ramLoad  = '0;
        #1;
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] ds);
        iRen   = ir;
        iAddr  = ia;
        dRen   = dr;
        dWen   = dw;
        dAddr  = da;
        dStore = ds;
        #1;
    endtask

    task automatic pushTxn(input logic isD, input logic we, input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        t.isD  = isD;
        t.we   = we;
        t.addr = addr;
        t.data = data;
        sb.push_back(t);
    endtask

    // Pulse ram_ready for the oldest expected transaction and check what the DUT presents.
    task automatic completeAccess();
        txn_t e;
        checkOutput("sbUnderflow", 64'(sb.size() == 0), 64'd0);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        ramReady = 1'b1;
        ramLoad  = e.we ? 32'hFFFF_FFFF : e.data;
        #1;
        checkOutput("ramAddr", ramAddr, e.addr);
        checkOutput("ramWen", ramWen, e.we);
        checkOutput("ramRen", ramRen, !e.we);
        if (e.we) checkOutput("ramStore", ramStore, e.data);
        if (e.isD) begin
            checkOutput("dWaitDone", dWait, 1'b0);
            if (!e.we) checkOutput("dLoad", dLoad, e.data);
            checkOutput("iWaitHeld", iWait, iRen);
            checkOutput("iLoadIdle", iLoad, 32'd0);
        end else begin
            checkOutput("iWaitDone", iWait, 1'b0);
            checkOutput("iLoad", iLoad, e.data);
            checkOutput("dWaitHeld", dWait, dRen | dWen);
            checkOutput("dLoadIdle", dLoad, 32'd0);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 32'h20, 32'h30);
        nextCycle();
        checkOutput("rstRamRen", ramRen, 1'b0);
        checkOutput("rstRamWen", ramWen, 1'b0);
        checkOutput("rstGnt", gntD, 1'b0);
        checkOutput("rstRamAddr", ramAddr, 32'd0);
        checkOutput("rstRamStore", ramStore, 32'd0);
        checkOutput("rstIWait", iWait, 1'b1);
        checkOutput("rstDWait", dWait, 1'b1);
        checkOutput("rstILoad", iLoad, 32'd0);
        checkOutput("rstDLoad", dLoad, 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        ramReady     = 1'b0;
        ramLoad      = '0;
        doReset();

        $display("[TB] single dcache read");
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0104, 32'd0);
        pushTxn(1'b1, 1'b0, 32'h104, 32'hDEAD_BEEF);
        checkOutput("t1IdleRen", ramRen, 1'b0);
        checkOutput("t1IdleDWait", dWait, 1'b1);
        nextCycle();
        checkOutput("t1Ren", ramRen, 1'b1);
        checkOutput("t1Addr", ramAddr, 32'h104);
        checkOutput("t1Gnt", gntD, 1'b1);
        checkOutput("t1DWaitHeld", dWait, 1'b1);
        nextCycle();
        completeAccess();
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("t1DropRen", ramRen, 1'b0);
        checkOutput("t1DWaitNoReq", dWait, 1'b0);
        checkOutput("t1DLoadCleared", dLoad, 32'd0);
        nextCycle();
        checkOutput("t1BackIdle", gntD, 1'b0);

        $display("[TB] dcache write, then read+write treated as write");
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0203, 32'h1234_5678);
        pushTxn(1'b1, 1'b1, 32'h200, 32'h1234_5678);
        checkOutput("t2IdleDWait", dWait, 1'b1);
        nextCycle();
        checkOutput("t2Wen", ramWen, 1'b1);
        checkOutput("t2RenLow", ramRen, 1'b0);
        checkOutput("t2Addr", ramAddr, 32'h200);
        nextCycle();
        completeAccess();
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0300, 32'hA5A5_5A5A);
        pushTxn(1'b1, 1'b1, 32'h300, 32'hA5A5_5A5A);
        checkOutput("t6Wen", ramWen, 1'b1);
        checkOutput("t6RenMasked", ramRen, 1'b0);
        checkOutput("t2DWaitReturns", dWait, 1'b1);
        nextCycle();
        completeAccess();
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("t6BurstEnd", gntD, 1'b0);
        checkOutput("t6NoWen", ramWen, 1'b0);

        $display("[TB] contention after reset with 2-word dcache burst");
        doReset();
        nextCycle();
        applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 32'h80, 32'd0);
        pushTxn(1'b1, 1'b0, 32'h80, 32'h1111_0080);
        pushTxn(1'b1, 1'b0, 32'h84, 32'h2222_0084);
        pushTxn(1'b0, 1'b0, 32'h400, 32'h3333_0400);
        checkOutput("t3IdleIWait", iWait, 1'b1);
        checkOutput("t3IdleDWait", dWait, 1'b1);
        nextCycle();
        checkOutput("t3DFirst", gntD, 1'b1);
        checkOutput("t3Addr0", ramAddr, 32'h80);
        checkOutput("t3ILoad", iLoad, 32'd0);
        nextCycle();
        completeAccess();
        nextCycle();
        applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 32'h84, 32'd0);
        checkOutput("t3Addr1", ramAddr, 32'h84);
        checkOutput("t3IWaitHeld", iWait, 1'b1);
        nextCycle();
        completeAccess();
        nextCycle();
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("t3IdleGap", ramRen, 1'b0);
        checkOutput("t3IWaitGap", iWait, 1'b1);
        checkOutput("t3GntDrop", gntD, 1'b0);
        nextCycle();
        checkOutput("t3IAddr", ramAddr, 32'h400);
        checkOutput("t3IRen", ramRen, 1'b1);
        nextCycle();
        completeAccess();
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("t3IWaitNoReq", iWait, 1'b0);
        nextCycle();

        $display("[TB] 3-word dcache stream with icache pending");
        applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 32'h90, 32'd0);
        pushTxn(1'b1, 1'b0, 32'h90, 32'h4444_0090);
        pushTxn(1'b1, 1'b0, 32'h94, 32'h5555_0094);
        pushTxn(1'b0, 1'b0, 32'h500, 32'h6666_0500);
        pushTxn(1'b1, 1'b0, 32'h98, 32'h7777_0098);
        checkOutput("t4IdleRen", ramRen, 1'b0);
        nextCycle();
        completeAccess();
        nextCycle();
        applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 32'h94, 32'd0);
        completeAccess();
        nextCycle();
        applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 32'h98, 32'd0);
        checkOutput("t4Yield", ramRen, 1'b0);
        checkOutput("t4DWaitHeld", dWait, 1'b1);
        checkOutput("t4IWaitHeld", iWait, 1'b1);
        nextCycle();
        completeAccess();
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h98, 32'd0);
        checkOutput("t4IAccDrop", ramRen, 1'b0);
        checkOutput("t4DWaitStill", dWait, 1'b1);
        nextCycle();
        checkOutput("t4IdleDWait", dWait, 1'b1);
        checkOutput("t4IdleGnt", gntD, 1'b0);
        nextCycle();
        completeAccess();
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        nextCycle();

        $display("[TB] reset during dcache access");
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h600, 32'd0);
        nextCycle();
        checkOutput("t5Ren", ramRen, 1'b1);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        checkOutput("t5RstIdle", ramRen, 1'b0);
        checkOutput("t5RstDWait", dWait, 1'b1);
        checkOutput("t5RstGnt", gntD, 1'b0);
        ramReady = 1'b1;
        ramLoad  = 32'h0000_0BAD;
        #1;
        checkOutput("t5LateReadyWait", dWait, 1'b1);
        checkOutput("t5LateReadyLoad", dLoad, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("t5AfterRen", ramRen, 1'b0);
        nextCycle();

        $display("[TB] icache abort mid-access");
        applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 32'd0, 32'd0);
        nextCycle();
        checkOutput("t7Ren", ramRen, 1'b1);
        checkOutput("t7Addr", ramAddr, 32'h700);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        ramReady = 1'b1;
        ramLoad  = 32'h0000_CAFE;
        #1;
        checkOutput("t7AbortRen", ramRen, 1'b0);
        checkOutput("t7AbortILoad", iLoad, 32'd0);
        checkOutput("t7AbortIWait", iWait, 1'b0);
        nextCycle();
        checkOutput("t7IdleGnt", gntD, 1'b0);
        checkOutput("t7IdleRen", ramRen, 1'b0);

        checkOutput("sbDrained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Memory-side responder to the icache and dcache request interfaces. It arbitrates the two cache masters onto a single-ported RAM.
- Caches issue word requests (iREN; dREN/dWEN) and hold them stable until their wait line drops. This block drives the RAM strobes and returns load data.
- A granted master keeps the RAM for up to BURST_MAX consecutive accesses, so a two-word block fill or writeback is never interleaved with the other cache's traffic.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width
BURST_MAX, 2, max consecutive completed accesses per grant (>=1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset; synchronous, active-high
iREN  in  1  icache read request
iaddr  in  ADDR_W  icache word address
iwait  out  1  icache stall; low only in the cycle its access completes
iload  out  DATA_W  icache read data, valid when iREN && !iwait
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  ADDR_W  dcache word address
dstore  in  DATA_W  dcache write data
dwait  out  1  dcache stall; low only in the cycle its access completes
dload  out  DATA_W  dcache read data, valid when dREN && !dwait
ram_ren  out  1  RAM read strobe
ram_wen  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address, bits [1:0] forced to 0
ram_store  out  DATA_W  RAM write data
ram_load  in  DATA_W  RAM read data, valid with ram_ready
ram_ready  in  1  one-cycle pulse when the RAM completes the current strobe
gnt_d  out  1  registered: dcache owns the RAM (debug/observation)

Behaviour:
- States: IDLE, D_ACC, I_ACC. Registered state: state, burst_cnt (width clog2(BURST_MAX)+1), last_d (last grant was dcache).
- Reset, taken on the CLK edge with RST=1:
  - State, counters and flags: state=IDLE, burst_cnt=0, last_d=0.
  - Strobes: ram_ren=ram_wen=0, gnt_d=0.
  - Address and data outputs: ram_addr, ram_store, iload and dload are 0.
  - Wait lines: iwait=iREN and dwait=(dREN|dWEN), i.e. no completion is reported.
- Wait lines in every state: iwait=1 while iREN, except the completion cycle; same rule for dwait with dREN|dWEN. With no request, the wait line is 0.
- IDLE:
  - No RAM strobes.
  - dcache pending only (dREN|dWEN) -> D_ACC; icache pending only (iREN) -> I_ACC.
  - Both pending -> the side not granted last (last_d=1 -> I_ACC, else D_ACC). After reset, dcache wins.
  - No request -> IDLE.
  - Grant takes effect the next cycle. Minimum request-to-completion latency is 1 cycle (IDLE cycle) + RAM latency.
- D_ACC:
  - RAM outputs are combinational from the dcache inputs: ram_ren=dREN&!dWEN, ram_wen=dWEN, ram_addr={daddr[ADDR_W-1:2],2'b00}, ram_store=dstore.
  - dREN&dWEN together is treated as a write; the read is ignored.
  - On ram_ready: dwait=0 and dload=ram_load in that cycle; burst_cnt+1; last_d<=1.
  - After the completion edge: go to IDLE if burst_cnt+1==BURST_MAX, or if the dcache drops its request in the next cycle; otherwise stay in D_ACC and serve the next word.
  - At that edge burst_cnt resets to 0 if leaving, else increments.
- I_ACC:
  - Same as D_ACC with iREN/iaddr: ram_ren=iREN, ram_wen=0. On ram_ready: iwait=0, iload=ram_load, last_d<=0.
- Continuation and abort:
  - Continuation is decided in the cycle after completion. If the owner has no request then, the state returns to IDLE with no strobes driven in that cycle.
  - A request dropped before ram_ready aborts: strobes deassert combinationally, next state is IDLE, burst_cnt=0, last_d unchanged. The RAM must tolerate strobe removal.
- Non-granted master: its wait line stays 1 and its load output stays 0 throughout the other master's grant.
- ram_ready outside D_ACC/I_ACC, or with no strobe asserted, is ignored.
- gnt_d is 1 in D_ACC, 0 otherwise.
- Reset mid-access: the synchronous edge forces IDLE, and strobes drop in the following cycle. An in-flight RAM completion is discarded.
- BURST_MAX=1: every completion returns to IDLE, giving strict alternation under contention.

Test Plan:
- Reset, then dREN=1, daddr=0x0000_0104, RAM ready after 2 cycles with ram_load=0xDEAD_BEEF -> ram_addr=0x104 and ram_ren=1 from cycle 1; dwait=0 and dload=0xDEADBEEF only in the ready cycle; state returns to IDLE.
- dWEN=1, daddr=0x0000_0203, dstore=0x1234_5678 -> ram_wen=1, ram_addr=0x200, ram_store=0x12345678; dwait drops for exactly one cycle on ready.
- Both iREN and dREN asserted right after reset; dcache issues a 2-word burst at 0x80 then 0x84 -> RAM sees 0x80, 0x84, then the icache address. iwait stays 1 until the icache's own ready; no interleaving.
- With BURST_MAX=2, dcache keeps requesting 3 words while iREN is pending -> after 2 completions the icache is granted. The third dcache word is served after the icache completes.
- Assert RST in the cycle before ram_ready during D_ACC -> next cycle IDLE, ram_ren=0, dwait=1. A late ram_ready pulse produces no dwait=0.
- dREN=dWEN=1 -> ram_wen=1, ram_ren=0.
- Icache drops iREN mid-access -> strobes drop, IDLE next cycle, no iwait=0 pulse.
